ap_sat_accum: RTL

//   Multi-lane saturating accumulator: sums a framed stream of signed terms per lane
//   (e.g. weight*state partial products feeding an RBM neuron's activation sum).

---
 rtl/ap_sat_accum.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ap_sat_accum.sv
// ap_sat_accum: multi-lane saturating accumulator over framed streams of signed terms.
// Each lane sums the terms of one frame (first..last beats) in saturate or wrap mode.
// The result is held with a per-lane sticky overflow flag and a beat count until the
// downstream stage accepts it.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready    input beat handshake
//   in_data                LANES packed signed terms, lane i = [i*BITLENGTH +: BITLENGTH]
//   in_first / in_last     frame delimiters for the current beat
//   mode_sat               1 = saturate, 0 = wrap; sampled on the first beat only
//   out_valid / out_ready  result handshake
//   out_data               per-lane sums, same packing as in_data
//   out_ovf                per-lane sticky overflow for the frame
//   out_count              beats in the frame, saturating at all-ones
module ap_sat_accum #(
  parameter int unsigned BITLENGTH = 16,
  parameter int unsigned LANES     = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*BITLENGTH-1:0] in_data,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic                       mode_sat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*BITLENGTH-1:0] out_data,
  output logic [LANES-1:0]           out_ovf,
  output logic [CNT_W-1:0]           out_count
);

  localparam int unsigned DW  = LANES * BITLENGTH;
  localparam int unsigned MSB = BITLENGTH - 1;

  // Symmetric clamp values: the most-negative code is never produced by saturation.
  localparam logic [BITLENGTH-1:0] MAX_POS = {1'b0, {(BITLENGTH-1){1'b1}}};
  localparam logic [BITLENGTH-1:0] MAX_NEG = {1'b1, {(BITLENGTH-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DW-1:0]      acc_q, acc_d;
  logic [LANES-1:0]   ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               in_ready_d;
  logic               out_valid_d;
  logic               load_out;

  logic               mode_use_c;
  logic [DW-1:0]      sum_c;
  logic [LANES-1:0]   lane_ovf_c;
  logic [BITLENGTH-1:0] op_a, op_b, op_t;

  // A first beat restarts from zero, so its own mode_sat applies to this add.
  assign mode_use_c = in_first ? mode_sat : mode_q;

  // Per-lane adder with overflow detect and optional symmetric clamp.
  always_comb begin
    sum_c      = '0;
    lane_ovf_c = '0;
    op_a       = '0;
    op_b       = '0;
    op_t       = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      op_a = in_first ? '0 : acc_q[i*BITLENGTH +: BITLENGTH];
      op_b = in_data[i*BITLENGTH +: BITLENGTH];
      op_t = op_a + op_b;
      if ((op_a[MSB] == op_b[MSB]) && (op_t[MSB] != op_a[MSB])) begin
        lane_ovf_c[i] = 1'b1;
        if (mode_use_c) begin
          op_t = op_a[MSB] ? MAX_NEG : MAX_POS;
        end
      end
      sum_c[i*BITLENGTH +: BITLENGTH] = op_t;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    load_out = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_first) begin
          acc_d  = sum_c;
          ovf_d  = '0;
          cnt_d  = CNT_W'(1);
          mode_d = mode_sat;
          if (in_last) begin
            state_d  = S_HOLD;
            load_out = 1'b1;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d = sum_c;
          if (in_first) begin
            // Restart discards the partial frame.
            ovf_d  = '0;
            cnt_d  = CNT_W'(1);
            mode_d = mode_sat;
          end else begin
            ovf_d = ovf_q | lane_ovf_c;
            cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          end
          if (in_last) begin
            state_d  = S_HOLD;
            load_out = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d  = (state_d != S_HOLD);
    out_valid_d = (state_d == S_HOLD);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      ovf_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= '0;
      out_count <= '0;
    end else begin
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      if (load_out) begin
        out_data  <= acc_d;
        out_ovf   <= ovf_d;
        out_count <= cnt_d;
      end
    end
  end

endmodule
